mips_mc_control: RTL
====================

// Module: mips_mc_control
// PURPOSE
//   Main control FSM for the multi-cycle MIPS datapath. Sequences fetch, decode, execute, memory and
//   writeback for lw/sw/R-type/beq/addi/j. Drives every datapath strobe and mux select, and generates
//   the 4-bit alu_ctrl consumed directly by the ALU. Counts retired instructions.
// PARAMETERS
//   USE_MEM_READY  1   1: memory states hold until mem_ready=1; 0: memory states take 1 cycle, mem_ready ignored
//   CNT_W          32  width of instr_count
// PORTS
//   clk            in   1      rising-edge clock
//   reset          in   1      synchronous, active-high
//   opcode         in   6      IR[31:26], stable after FETCH completes
//   funct          in   6      IR[5:0]
//   mem_ready      in   1      memory access complete this cycle
//   pc_write       out  1      unconditional PC load
//   pc_write_cond  out  1      PC load if ALU zero (beq)
//   iord           out  1      0: mem addr=PC, 1: mem addr=ALUOut
//   mem_read       out  1      memory read strobe
//   mem_write      out  1      memory write strobe
//   ir_write       out  1      IR load
//   mem_to_reg     out  1      1: writeback from MDR, 0: from ALUOut
//   reg_dst        out  1      1: rd, 0: rt
//   reg_write      out  1      register file write
//   alu_src_a      out  1      0: PC, 1: reg A
//   alu_src_b      out  2      00: B, 01: const 4, 10: sign-ext imm, 11: sign-ext imm<<2
//   pc_src         out  2      00: ALU result, 01: ALUOut, 10: jump target
//   alu_ctrl       out  4      0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt, 1111 invalid (ALU yields 0)
//   state          out  4      current state encoding (debug)
//   instr_count    out  CNT_W  retired-instruction counter
// BEHAVIOUR
//   States: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXEC=6 ALUWB=7 BRANCH=8 ADDIEX=9 ADDIWB=10 JUMP=11
//   Opcodes: R=000000 lw=100011 sw=101011 beq=000100 addi=001000 j=000010.
//   Transitions:
//   - FETCH->DECODE when mem_ready (or always if USE_MEM_READY=0).
//   - DECODE: lw/sw->MEMADR, R->EXEC, beq->BRANCH, addi->ADDIEX, j->JUMP, other->FETCH.
//   - MEMADR: lw->MEMRD, sw->MEMWR. MEMRD->MEMWB on mem_ready. MEMWR->FETCH on mem_ready.
//   - MEMWB, ALUWB, BRANCH, ADDIWB, JUMP -> FETCH. EXEC->ALUWB. ADDIEX->ADDIWB. States 12-15 -> FETCH.
//   Moore outputs (unlisted = 0):
//   - FETCH: mem_read, ir_write, alu_src_b=01, alu 0010.
//     pc_write and ir_write only in the cycle FETCH exits, i.e. qualified by mem_ready when USE_MEM_READY=1.
//   - DECODE: alu_src_b=11, alu 0010. MEMADR/ADDIEX: alu_src_a=1, alu_src_b=10, alu 0010.
//   - MEMRD: mem_read, iord. MEMWR: mem_write, iord. MEMWB: reg_write, mem_to_reg.
//   - EXEC: alu_src_a=1, alu_src_b=00, alu_ctrl from funct: 100000 0010, 100010 0110, 100100 0000,
//     100101 0001, 101010 0111, else 1111. ALUWB: reg_write, reg_dst.
//   - ADDIWB: reg_write. BRANCH: alu_src_a=1, alu 0110, pc_write_cond, pc_src=01. JUMP: pc_write, pc_src=10.
//   - alu_ctrl=0010 in all states not listed.
//   Retire: instr_count += 1 (wraps modulo 2^CNT_W) on the cycle leaving MEMWB, MEMWR (mem_ready),
//     ALUWB, BRANCH, ADDIWB, JUMP, or DECODE with an unknown opcode.
//   Reset: while reset=1 all strobes (pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write)
//     forced 0. Mux selects 0, alu_ctrl=0010. At the edge: state<=FETCH, instr_count<=0.
//     Reset mid-instruction abandons it with no retire. First fetch begins the cycle after reset deasserts.
//   Latency (mem_ready tied 1): lw 5, sw 4, R 4, addi 4, beq 3, j 3, unknown 2 cycles.
// TESTING
//   - reset 2 cycles, then lw with mem_ready=1: states 0,1,2,3,4,0.
//     reg_write&mem_to_reg only in state 4; instr_count=1.
//   - R-type funct=101010: alu_ctrl=0111 in EXEC, reg_write&reg_dst in ALUWB; funct=111111 -> alu_ctrl=1111.
//   - sw with mem_ready low 3 cycles in MEMWR: mem_write held 4 cycles, no retire until mem_ready=1.
//   - beq: BRANCH shows alu_ctrl=0110, pc_write_cond=1, pc_src=01.
//     j: pc_write=1, pc_src=10; each exactly 1 cycle.
//   - opcode=111111: FETCH,DECODE,FETCH, count+1, no reg_write/mem_write.
//     Reset asserted in MEMRD -> state 0, count 0, all strobes 0.
//   - USE_MEM_READY=0 with mem_ready tied 0: lw still completes in 5 cycles.
//     Force count to 2^CNT_W-1, retire one -> 0.

Source files
------------

// File: rtl/mips_mc_control.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences each instruction,
// drives datapath strobes/mux selects and the ALU operation, and counts retirements.
module mips_mc_control #(
    parameter bit USE_MEM_READY = 1'b1,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic [3:0]       alu_ctrl,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
        BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_INV = 4'b1111;

    state_t st;
    logic   mem_ok;

    // With handshaking disabled every memory state completes in one cycle.
    assign mem_ok = USE_MEM_READY ? mem_ready : 1'b1;
    assign state  = st;

    always_ff @(posedge clk) begin
        if (reset) begin
            st          <= FETCH;
            instr_count <= '0;
        end else begin
            case (st)
                FETCH:  if (mem_ok) st <= DECODE;
                DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: st <= MEMADR;
                        OP_R:         st <= EXEC;
                        OP_BEQ:       st <= BRANCH;
                        OP_ADDI:      st <= ADDIEX;
                        OP_J:         st <= JUMP;
                        default: begin
                            st          <= FETCH;
                            instr_count <= instr_count + CNT_W'(1);
                        end
                    endcase
                end
                // Only lw and sw reach the address state.
                MEMADR: st <= (opcode == OP_SW) ? MEMWR : MEMRD;
                MEMRD:  if (mem_ok) st <= MEMWB;
                MEMWR: begin
                    if (mem_ok) begin
                        st          <= FETCH;
                        instr_count <= instr_count + CNT_W'(1);
                    end
                end
                EXEC:   st <= ALUWB;
                ADDIEX: st <= ADDIWB;
                MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: begin
                    st          <= FETCH;
                    instr_count <= instr_count + CNT_W'(1);
                end
                default: st <= FETCH;
            endcase
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_src        = 2'b00;
        alu_ctrl      = ALU_ADD;
        if (!reset) begin
            case (st)
                FETCH: begin
                    mem_read  = 1'b1;
                    // PC and IR load only on the cycle the fetch actually completes.
                    ir_write  = mem_ok;
                    pc_write  = mem_ok;
                    alu_src_b = 2'b01;
                end
                DECODE: alu_src_b = 2'b11;
                MEMADR, ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                MEMWR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                EXEC: begin
                    alu_src_a = 1'b1;
                    case (funct)
                        6'b100000: alu_ctrl = ALU_ADD;
                        6'b100010: alu_ctrl = ALU_SUB;
                        6'b100100: alu_ctrl = ALU_AND;
                        6'b100101: alu_ctrl = ALU_OR;
                        6'b101010: alu_ctrl = ALU_SLT;
                        default:   alu_ctrl = ALU_INV;
                    endcase
                end
                ALUWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                ADDIWB: reg_write = 1'b1;
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_ctrl      = ALU_SUB;
                    pc_write_cond = 1'b1;
                    pc_src        = 2'b01;
                end
                JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = 2'b10;
                end
                default: ;
            endcase
        end
    end
endmodule
